// File: rtl/msb_pkg.sv
// msb_pkg: width derivation helpers and the response flag bundle shared by
// multichannel_sample_buffer and msb_channel_history.
package msb_pkg;

  // Channel select width; at least one bit even for a single channel.
  function automatic int msb_chan_w(input int num_channels);
    return (num_channels <= 2) ? 1 : $clog2(num_channels);
  endfunction

  // Age index width; at least one bit.
  function automatic int msb_idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Running-sum width: wide enough for DEPTH full-scale samples.
  function automatic int msb_sum_w(input int sample_width, input int depth);
    return sample_width + $clog2(depth + 1);
  endfunction

  // Response status carried alongside the registered read data.
  typedef struct packed {
    logic valid;
    logic err;
  } msb_rsp_flags_t;

endpackage

// File: rtl/msb_channel_history.sv
// msb_channel_history: one channel's sample history as a shift register
// (slot 0 = newest), a saturating fill counter and, when MSB_SUM_EN is
// defined, a running sum of the filled slots.
module msb_channel_history
  import msb_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10,
  localparam int IDX_W       = msb_idx_w(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [SAMPLE_WIDTH-1:0]       wr_data,
  output logic [DEPTH*SAMPLE_WIDTH-1:0] slots,
`ifdef MSB_SUM_EN
  output logic [msb_sum_w(SAMPLE_WIDTH, DEPTH)-1:0] sum,
`endif
  output logic [IDX_W:0]                fill
);

  localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

  logic [SAMPLE_WIDTH-1:0] hist [DEPTH];

  // Shift in the new sample and count up until the history is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
      fill <= '0;
    end else if (wr_en) begin
      hist[0] <= wr_data;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slots
    assign slots[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = hist[k];
  end

`ifdef MSB_SUM_EN
  localparam int SUM_W = msb_sum_w(SAMPLE_WIDTH, DEPTH);

  // Only a full history actually loses its oldest sample on a write.
  logic [SAMPLE_WIDTH-1:0] evicted;
  assign evicted = (fill == FULL) ? hist[DEPTH-1] : '0;

  // Running sum tracks exactly the samples currently held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (wr_en) begin
      sum <= sum + SUM_W'(wr_data) - SUM_W'(evicted);
    end
  end
`endif

endmodule

// File: rtl/multichannel_sample_buffer.sv
// multichannel_sample_buffer: per-channel history of the last DEPTH samples
// with registered random reads by (channel, age). Define MSB_SUM_EN to build
// a per-channel running sum reported on rd_sum; otherwise rd_sum is tied to 0.
//
// Read handshake: there is no ready. Every cycle with ena & rd_req is
// accepted, and exactly one cycle later rd_valid pulses high for one cycle
// with rd_data/rd_err/rd_fill/rd_sum describing the state before the request
// edge. Without a request rd_valid is low and the data fields hold.
module multichannel_sample_buffer
  import msb_pkg::*;
#(
  parameter int NUM_CHANNELS = 7,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10,
  localparam int CHAN_W      = msb_chan_w(NUM_CHANNELS),
  localparam int IDX_W       = msb_idx_w(DEPTH),
  localparam int SUM_W       = msb_sum_w(SAMPLE_WIDTH, DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    freeze,
  input  logic                    wr_valid,
  input  logic [CHAN_W-1:0]       wr_chan,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    rd_req,
  input  logic [CHAN_W-1:0]       rd_chan,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_err,
  output logic [IDX_W:0]          rd_fill,
  output logic [SUM_W-1:0]        rd_sum,
  output logic [7:0]              drop_cnt
);

  logic [DEPTH*SAMPLE_WIDTH-1:0] ch_slots [NUM_CHANNELS];
  logic [IDX_W:0]                ch_fill  [NUM_CHANNELS];
`ifdef MSB_SUM_EN
  logic [SUM_W-1:0]              ch_sum   [NUM_CHANNELS];
`endif
  logic [NUM_CHANNELS-1:0]       ch_wr_en;

  // Write decode: an out-of-range channel matches nothing and is ignored.
  always_comb begin
    ch_wr_en = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_wr_en[c] = ena & wr_valid & ~freeze & (wr_chan == CHAN_W'(c));
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    msb_channel_history #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .DEPTH        (DEPTH)
    ) u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ch_wr_en[c]),
      .wr_data (wr_data),
      .slots   (ch_slots[c]),
`ifdef MSB_SUM_EN
      .sum     (ch_sum[c]),
`endif
      .fill    (ch_fill[c])
    );
  end

  logic [DEPTH*SAMPLE_WIDTH-1:0] sel_slots;
  logic [IDX_W:0]                sel_fill;
  logic [SAMPLE_WIDTH-1:0]       sel_data;
  logic                          chan_ok;
  logic                          err_next;
`ifdef MSB_SUM_EN
  logic [SUM_W-1:0]              sel_sum;
`endif

  // Read mux on pre-edge state; unmatched selects fall back to zero.
  always_comb begin
    sel_slots = '0;
    sel_fill  = '0;
`ifdef MSB_SUM_EN
    sel_sum   = '0;
`endif
    chan_ok   = ({1'b0, rd_chan} < (CHAN_W + 1)'(NUM_CHANNELS));
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_chan == CHAN_W'(c)) begin
        sel_slots = ch_slots[c];
        sel_fill  = ch_fill[c];
`ifdef MSB_SUM_EN
        sel_sum   = ch_sum[c];
`endif
      end
    end
    sel_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_idx == IDX_W'(k)) sel_data = sel_slots[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    err_next = ~chan_ok
             | ({1'b0, rd_idx} >= (IDX_W + 1)'(DEPTH))
             | ({1'b0, rd_idx} >= sel_fill);
  end

  msb_rsp_flags_t rsp_q;
  assign rd_valid = rsp_q.valid;
  assign rd_err   = rsp_q.err;

  // Response registers: one-cycle valid pulse, fields hold between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q   <= '0;
      rd_data <= '0;
      rd_fill <= '0;
    end else if (ena & rd_req) begin
      rsp_q.valid <= 1'b1;
      rsp_q.err   <= err_next;
      rd_data     <= err_next ? '0 : sel_data;
      rd_fill     <= sel_fill;
    end else begin
      rsp_q.valid <= 1'b0;
    end
  end

`ifdef MSB_SUM_EN
  // Sum is reported with the same latency and hold behaviour as rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sum <= '0;
    end else if (ena & rd_req) begin
      rd_sum <= err_next ? '0 : sel_sum;
    end
  end
`else
  assign rd_sum = '0;
`endif

  // Count writes lost to freeze, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (ena & wr_valid & freeze & (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_multichannel_sample_buffer.sv
// Directed bench for multichannel_sample_buffer at the default parameters
// (7 channels, 8-bit samples, depth 10). rd_sum expectations follow
// MSB_SUM_EN: real sums when defined, zero otherwise.
module tb_multichannel_sample_buffer;

  localparam int CHAN_W = 3;
  localparam int IDX_W  = 4;
  localparam int SUM_W  = 12;
  localparam int RSP_W  = 2 + (IDX_W + 1) + 8 + SUM_W;
`ifdef MSB_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              freeze;
  logic              wr_valid;
  logic [CHAN_W-1:0] wr_chan;
  logic [7:0]        wr_data;
  logic              rd_req;
  logic [CHAN_W-1:0] rd_chan;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_err;
  logic [IDX_W:0]    rd_fill;
  logic [SUM_W-1:0]  rd_sum;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [RSP_W-1:0] exp_q[$];
  logic [RSP_W-1:0] obs;
  logic [RSP_W-1:0] exp_v;

  assign obs = {rd_valid, rd_err, rd_fill, rd_data, rd_sum};

  multichannel_sample_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .freeze   (freeze),
    .wr_valid (wr_valid),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_chan  (rd_chan),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_fill  (rd_fill),
    .rd_sum   (rd_sum),
    .drop_cnt (drop_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected response word {valid, err, fill, data, sum}
  function automatic logic [RSP_W-1:0] rsp(input logic v, input logic e,
                                           input logic [IDX_W:0] f,
                                           input logic [7:0] d,
                                           input logic [SUM_W-1:0] s);
    return {v, e, f, d, (SUM_ON ? s : {SUM_W{1'b0}})};
  endfunction

  // Driver tasks: inputs change on the falling edge
  task automatic write_sample(input logic [CHAN_W-1:0] c, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_chan  = c;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Issue one read; returns at the falling edge after the response edge.
  task automatic issue_read(input logic [CHAN_W-1:0] c, input logic [IDX_W-1:0] i);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_chan = c;
    rd_idx  = i;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, {RSP_W{1'b0}});
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    end
    rst_n = 1'b1;
    issue_read(3'd0, 4'd0);
    exp_v = rsp(1'b1, 1'b1, 5'd0, 8'h00, 12'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL empty_read: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = rsp(1'b0, 1'b1, 5'd0, 8'h00, 12'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL idle_hold: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_basic_write();
    logic [7:0] vals [4];
    vals[0] = 8'h33; vals[1] = 8'h22; vals[2] = 8'h11; vals[3] = 8'h00;
    write_sample(3'd2, 8'h11);
    write_sample(3'd2, 8'h22);
    write_sample(3'd2, 8'h33);
    for (int i = 0; i < 4; i++) begin
      issue_read(3'd2, IDX_W'(i));
      if (i < 3) exp_v = rsp(1'b1, 1'b0, 5'd3, vals[i], 12'h066);
      else       exp_v = rsp(1'b1, 1'b1, 5'd3, 8'h00, 12'd0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch2_idx%0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_ena_low();
    @(negedge clk);
    ena      = 1'b0;
    wr_valid = 1'b1;
    wr_chan  = 3'd2;
    wr_data  = 8'h99;
    rd_req   = 1'b1;
    rd_chan  = 3'd2;
    rd_idx   = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL ena_low_valid: got %b expected 0", rd_valid);
    end
    freeze = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ena_low_drop: got %0d expected 0", drop_cnt);
    end
    ena      = 1'b1;
    freeze   = 1'b0;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    issue_read(3'd2, 4'd0);
    exp_v = rsp(1'b1, 1'b0, 5'd3, 8'h33, 12'h066);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ena_low_hold: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 12; i++) write_sample(3'd6, 8'(i));
    issue_read(3'd5, 4'd0);
    exp_v = rsp(1'b1, 1'b1, 5'd0, 8'h00, 12'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ch5_empty: got %h expected %h", obs, exp_v);
    end
  endtask

  // Streamed reads of ch6 idx 0..10, one per cycle, scored via exp_q.
  task automatic test_back_to_back();
    @(negedge clk);
    for (int k = 0; k <= 10; k++) begin
      rd_req  = 1'b1;
      rd_chan = 3'd6;
      rd_idx  = IDX_W'(k);
      if (k < 10) exp_q.push_back(rsp(1'b1, 1'b0, 5'd10, 8'(12 - k), 12'd75));
      else        exp_q.push_back(rsp(1'b1, 1'b1, 5'd10, 8'h00, 12'd0));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ch6_stream_idx%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_freeze();
    @(negedge clk);
    freeze   = 1'b1;
    wr_valid = 1'b1;
    wr_chan  = 3'd2;
    wr_data  = 8'hFF;
    repeat (10) @(negedge clk);
    checks++;
    if (drop_cnt !== 8'd10) begin
      errors++;
      $display("FAIL drop_count_10: got %0d expected 10", drop_cnt);
    end
    repeat (290) @(negedge clk);
    wr_valid = 1'b0;
    freeze   = 1'b0;
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
    end
    issue_read(3'd2, 4'd0);
    exp_v = rsp(1'b1, 1'b0, 5'd3, 8'h33, 12'h066);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL freeze_hold: got %h expected %h", obs, exp_v);
    end
    write_sample(3'd7, 8'h5A);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL bad_chan_drop: got %0d expected 255", drop_cnt);
    end
    issue_read(3'd0, 4'd0);
    exp_v = rsp(1'b1, 1'b1, 5'd0, 8'h00, 12'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bad_chan_ch0: got %h expected %h", obs, exp_v);
    end
    issue_read(3'd6, 4'd0);
    exp_v = rsp(1'b1, 1'b0, 5'd10, 8'd12, 12'd75);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bad_chan_ch6: got %h expected %h", obs, exp_v);
    end
    issue_read(3'd7, 4'd0);
    exp_v = rsp(1'b1, 1'b1, 5'd0, 8'h00, 12'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL read_bad_chan: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_same_cycle();
    write_sample(3'd1, 8'h55);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_chan  = 3'd1;
    wr_data  = 8'hAA;
    rd_req   = 1'b1;
    rd_chan  = 3'd1;
    rd_idx   = 4'd0;
    @(negedge clk);
    wr_valid = 1'b0;
    exp_v = rsp(1'b1, 1'b0, 5'd1, 8'h55, 12'h055);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL same_cycle_old: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    rd_req = 1'b0;
    exp_v = rsp(1'b1, 1'b0, 5'd2, 8'hAA, 12'h0FF);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL same_cycle_new: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rd_req  = 1'b1;
    rd_chan = 3'd6;
    rd_idx  = 4'd0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected %h", obs, {RSP_W{1'b0}});
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_drop: got %0d expected 0", drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue_read(3'd6, 4'd0);
    exp_v = rsp(1'b1, 1'b1, 5'd0, 8'h00, 12'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_ch6: got %h expected %h", obs, exp_v);
    end
    issue_read(3'd2, 4'd0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset_ch2: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    freeze   = 1'b0;
    wr_valid = 1'b0;
    wr_chan  = '0;
    wr_data  = '0;
    rd_req   = 1'b0;
    rd_chan  = '0;
    rd_idx   = '0;
    test_reset();
    test_basic_write();
    test_ena_low();
    test_wrap();
    test_back_to_back();
    test_freeze();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
